multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the RV32 datapath: PC, instruction memory, register file, immediate generator, ALU, and the PC and immediate muxes.
- Replaces single-cycle decode with an FSM that fetches through a req/ack handshake to instruction memory, then decodes, executes and writes back addi, add, beq and jal.
- Traps on illegal opcodes and on fetch timeouts.
- Counts retired instructions for the Fibonacci program bench.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter
- FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before trap (>=2)

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- run  in  1  enable; sampled in IDLE and at each instruction boundary
- opcode  in  7  instruction register bits [6:0]; valid from DECODE onward
- alu_zero  in  1  ALU zero flag (operand1 - operand2 == 0)
- imem_ack  in  1  instruction memory data valid
- imem_req  out  1  fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC this cycle
- pc_sel  out  1  0: pc+4, 1: pc+imm
- alu_src  out  1  0: read_data2, 1: imm_out
- alu_op  out  2  00 add, 01 sub, others reserved (never driven)
- reg_write  out  1  register file write enable
- wb_sel  out  1  0: alu_result, 1: pc+4
- trap  out  1  sticky error flag
- retired  out  CNT_WIDTH  instructions completed
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE, trap=0, retired=0, timeout counter=0. All outputs 0 while in reset.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, TRAP=5.
- Outputs are decoded from state and opcode/alu_zero. Every output not listed for a state is 0.
- IDLE:
  - run=1 -> FETCH; otherwise stay.
- FETCH:
  - imem_req=1.
  - ir_write = imem_ack (same cycle).
  - On imem_ack -> DECODE and clear the timeout counter.
  - Otherwise increment the timeout counter. When it reaches FETCH_TIMEOUT-1 with no ack -> TRAP.
- DECODE (1 cycle, register read):
  - opcode in {0010011 addi, 0110011 add, 1100011 beq, 1101111 jal} -> EXEC.
  - Any other opcode -> TRAP. No pc_write, no reg_write.
- EXEC:
  - addi: alu_src=1, alu_op=00 -> WB.
  - add: alu_src=0, alu_op=00 -> WB.
  - beq: alu_src=0, alu_op=01, pc_write=1, pc_sel=alu_zero. Instruction ends here.
  - jal: no ALU use -> WB.
- WB:
  - addi/add: reg_write=1, wb_sel=0, pc_write=1, pc_sel=0.
  - jal: reg_write=1, wb_sel=1, pc_write=1, pc_sel=1. The PC register updates on the clock edge, so rd receives the old pc+4.
- Instruction boundary = any cycle with pc_write=1:
  - retired increments by 1 on that edge, wrapping modulo 2^CNT_WIDTH.
  - Next state is FETCH if run=1, else IDLE.
- Latency with ack in the first FETCH cycle: addi/add/jal = 4 cycles, beq = 3 cycles. Each wait cycle in FETCH adds 1.
- rd=x0: reg_write is still asserted; the register file discards the write.
- TRAP: trap=1 and held. All other control outputs 0. Exit only by reset. run is ignored.
- run deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- imem_ack outside FETCH: ignored.
- Reset asserted mid-instruction: immediate return to IDLE. No partial pc_write or reg_write is issued after the reset edge.

Test Plan:
- Reset release, run=1, imem_ack tied 1, addi x1,x0,5 -> state sequence 1,2,3,4,1. One reg_write pulse with wb_sel=0. pc_write with pc_sel=0. retired=1 after 4 cycles.
- beq x1,x2,+8, register values equal (alu_zero=1) -> EXEC asserts alu_op=01, pc_write=1, pc_sel=1, reg_write=0. Next state FETCH after 3 cycles. Repeat with alu_zero=0 -> pc_sel=0.
- jal x1,+16 -> WB asserts reg_write=1, wb_sel=1, pc_write=1, pc_sel=1. x1 = old_pc+4, PC = old_pc+16.
- imem_ack delayed 3 cycles -> imem_req held 4 cycles. ir_write pulses exactly once, in the ack cycle. Instruction latency is 7 cycles for add.
- imem_ack never asserted, FETCH_TIMEOUT=16 -> TRAP entered after 16 FETCH cycles. trap stays 1 for 50 further cycles. retired is unchanged.
- Opcode 0000011 -> DECODE then TRAP, no pc_write. Separately, reset asserted during EXEC of add -> state_o=0, retired=0, no reg_write.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath: fetch via req/ack handshake,
// then decode, execute and write back addi/add/beq/jal, with sticky trap and retire counter.
module multicycle_control_fsm #(
    parameter int CNT_WIDTH     = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 alu_zero,
    input  logic                 imem_ack,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 wb_sel,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam int TW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

    state_t                 state_r;
    state_t                 state_s;
    logic [TW-1:0]          tcnt_r;
    logic [TW-1:0]          tcnt_s;
    logic [CNT_WIDTH-1:0]   retired_r;

    logic                   imem_req_s;
    logic                   ir_write_s;
    logic                   pc_write_s;
    logic                   pc_sel_s;
    logic                   alu_src_s;
    logic [1:0]             alu_op_s;
    logic                   reg_write_s;
    logic                   wb_sel_s;
    logic                   trap_s;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_ADDI) || (op == OP_ADD) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

    // Next-state, timeout counter and control-output decode.
    always_comb begin
        state_s     = state_r;
        tcnt_s      = tcnt_r;
        imem_req_s  = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc_sel_s    = 1'b0;
        alu_src_s   = 1'b0;
        alu_op_s    = 2'b00;
        reg_write_s = 1'b0;
        wb_sel_s    = 1'b0;
        trap_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) state_s = S_FETCH;
                else     state_s = S_IDLE;
            end
            S_FETCH: begin
                imem_req_s = 1'b1;
                ir_write_s = imem_ack;
                if (imem_ack) begin
                    state_s = S_DECODE;
                    tcnt_s  = '0;
                end else if (tcnt_r == TO_LAST) begin
                    state_s = S_TRAP;
                end else begin
                    tcnt_s = tcnt_r + TW'(1);
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) state_s = S_EXEC;
                else                  state_s = S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADDI: begin
                        alu_src_s = 1'b1;
                        state_s   = S_WB;
                    end
                    OP_ADD:  state_s = S_WB;
                    OP_JAL:  state_s = S_WB;
                    // Branch completes here: the compare and PC update share one cycle.
                    OP_BEQ: begin
                        alu_op_s   = 2'b01;
                        pc_write_s = 1'b1;
                        pc_sel_s   = alu_zero;
                        state_s    = run ? S_FETCH : S_IDLE;
                    end
                    default: state_s = S_TRAP;
                endcase
            end
            S_WB: begin
                case (opcode)
                    OP_ADDI, OP_ADD: begin
                        reg_write_s = 1'b1;
                        pc_write_s  = 1'b1;
                        state_s     = run ? S_FETCH : S_IDLE;
                    end
                    OP_JAL: begin
                        reg_write_s = 1'b1;
                        wb_sel_s    = 1'b1;
                        pc_write_s  = 1'b1;
                        pc_sel_s    = 1'b1;
                        state_s     = run ? S_FETCH : S_IDLE;
                    end
                    default: state_s = S_TRAP;
                endcase
            end
            S_TRAP: begin
                trap_s  = 1'b1;
                state_s = S_TRAP;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, fetch-timeout counter and retired-instruction counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r   <= S_IDLE;
            tcnt_r    <= '0;
            retired_r <= '0;
        end else begin
            state_r <= state_s;
            tcnt_r  <= tcnt_s;
            if (pc_write_s) retired_r <= retired_r + CNT_WIDTH'(1);
            else            retired_r <= retired_r;
        end
    end

    assign imem_req  = imem_req_s;
    assign ir_write  = ir_write_s;
    assign pc_write  = pc_write_s;
    assign pc_sel    = pc_sel_s;
    assign alu_src   = alu_src_s;
    assign alu_op    = alu_op_s;
    assign reg_write = reg_write_s;
    assign wb_sel    = wb_sel_s;
    assign trap      = trap_s;
    assign retired   = retired_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level schedule model
// predicts every cycle's outputs; a single negedge process compares them.
module tb_multicycle_control_fsm;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       irw;
        logic       pcw;
        logic       pcsel;
        logic       asrc;
        logic [1:0] aop;
        logic       rw;
        logic       wbs;
        logic       trp;
    } exp_t;

    logic        clk;
    logic        arst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        alu_zero;
    logic        imem_ack;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_sel;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        wb_sel;
    logic        trap;
    logic [31:0] retired;
    logic [2:0]  state_o;

    multicycle_control_fsm #(.CNT_WIDTH(32), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .arst_n(arst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ack(imem_ack), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .trap(trap), .retired(retired), .state_o(state_o)
    );

    int          total = 0;
    int          bad = 0;
    logic        chk_en = 1'b0;
    logic        g_rst = 1'b0;
    exp_t        ex;
    logic [31:0] e_ret;
    logic [31:0] m_ret = 32'd0;
    int unsigned run_pct = 100;
    logic        cont;
    logic        trapped;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model's prediction.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state",     32'(state_o),   32'(ex.st));
            check("imem_req",  32'(imem_req),  32'(ex.req));
            check("ir_write",  32'(ir_write),  32'(ex.irw));
            check("pc_write",  32'(pc_write),  32'(ex.pcw));
            check("pc_sel",    32'(pc_sel),    32'(ex.pcsel));
            check("alu_src",   32'(alu_src),   32'(ex.asrc));
            check("alu_op",    32'(alu_op),    32'(ex.aop));
            check("reg_write", 32'(reg_write), 32'(ex.rw));
            check("wb_sel",    32'(wb_sel),    32'(ex.wbs));
            check("trap",      32'(trap),      32'(ex.trp));
            check("retired",   retired,        e_ret);
        end
    end

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic rndb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rr();
        return ($urandom_range(0, 99) < run_pct);
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return (op == ADDI) || (op == ADD) || (op == BEQ) || (op == JAL);
    endfunction

    // One clock cycle: drive inputs after the edge and publish the expected outputs.
    task automatic step(input logic r, input logic a, input logic [6:0] op, input logic z, input exp_t e);
        @(posedge clk);
        #1;
        arst_n   = g_rst;
        run      = r;
        imem_ack = a;
        opcode   = op;
        alu_zero = z;
        ex       = e;
        e_ret    = m_ret;
        if (e.pcw) m_ret = m_ret + 32'd1;
        chk_en   = 1'b1;
    endtask

    // Whole instruction from its first FETCH cycle to its boundary (or trap entry).
    task automatic do_instr(input logic [6:0] op, input int delay, input logic z,
                            output logic nxt_run, output logic trp);
        exp_t e;
        logic r;
        nxt_run = 1'b0;
        trp     = 1'b0;
        for (int w = 0; w < delay; w++) begin
            e = mk(3'd1); e.req = 1'b1;
            step(rr(), 1'b0, rnd7(), rndb(), e);
        end
        e = mk(3'd1); e.req = 1'b1; e.irw = 1'b1;
        step(rr(), 1'b1, rnd7(), rndb(), e);
        step(rr(), rndb(), op, rndb(), mk(3'd2));
        if (!legal(op)) begin
            trp = 1'b1;
            return;
        end
        r = rr();
        e = mk(3'd3);
        if (op == ADDI) e.asrc = 1'b1;
        if (op == BEQ) begin
            e.aop = 2'b01; e.pcw = 1'b1; e.pcsel = z;
        end
        step(r, rndb(), op, z, e);
        if (op == BEQ) begin
            nxt_run = r;
            return;
        end
        r = rr();
        e = mk(3'd4); e.rw = 1'b1; e.pcw = 1'b1;
        if (op == JAL) begin
            e.wbs = 1'b1; e.pcsel = 1'b1;
        end
        step(r, rndb(), op, rndb(), e);
        nxt_run = r;
    endtask

    task automatic trap_cycles(input int n);
        exp_t e;
        e = mk(3'd5); e.trp = 1'b1;
        for (int k = 0; k < n; k++) step(rndb(), rndb(), rnd7(), rndb(), e);
    endtask

    task automatic do_reset();
        g_rst = 1'b0;
        m_ret = 32'd0;
        step(rndb(), rndb(), rnd7(), rndb(), mk(3'd0));
        step(rndb(), rndb(), rnd7(), rndb(), mk(3'd0));
        g_rst = 1'b1;
        step(1'b0, rndb(), rnd7(), rndb(), mk(3'd0));
    endtask

    task automatic go_idle_then_start();
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) step(1'b0, rndb(), rnd7(), rndb(), mk(3'd0));
        step(1'b1, rndb(), rnd7(), rndb(), mk(3'd0));
    endtask

    initial begin
        exp_t e;
        logic [6:0] op;
        arst_n = 1'b0; run = 1'b0; opcode = 7'd0; alu_zero = 1'b0; imem_ack = 1'b0;
        ex = '0; e_ret = 32'd0;

        do_reset();
        @(negedge clk);
        check("post_reset_state", 32'(state_o), 32'd0);
        check("post_reset_retired", retired, 32'd0);

        run_pct = 100;
        step(1'b1, 1'b0, rnd7(), 1'b0, mk(3'd0));
        do_instr(ADDI, 0, 1'b0, cont, trapped);
        @(negedge clk);
        check("addi_wb_reg_write", 32'(reg_write), 32'd1);
        check("addi_wb_wb_sel", 32'(wb_sel), 32'd0);
        check("addi_wb_pc_sel", 32'(pc_sel), 32'd0);
        check("addi_wb_state", 32'(state_o), 32'd4);

        do_instr(BEQ, 0, 1'b1, cont, trapped);
        @(negedge clk);
        check("beq_taken_pc_sel", 32'(pc_sel), 32'd1);
        check("beq_taken_alu_op", 32'(alu_op), 32'd1);
        check("beq_taken_reg_write", 32'(reg_write), 32'd0);
        check("retired_after_addi", retired, 32'd1);

        do_instr(BEQ, 0, 1'b0, cont, trapped);
        @(negedge clk);
        check("beq_not_taken_pc_sel", 32'(pc_sel), 32'd0);

        do_instr(JAL, 0, 1'b0, cont, trapped);
        @(negedge clk);
        check("jal_wb_sel", 32'(wb_sel), 32'd1);
        check("jal_pc_sel", 32'(pc_sel), 32'd1);
        check("retired_before_jal", retired, 32'd3);

        do_instr(ADD, 3, 1'b0, cont, trapped);

        // Random instruction mix with random run, ack delay and branch outcomes.
        run_pct = 75;
        for (int i = 0; i < 250; i++) begin
            if (!cont) go_idle_then_start();
            if ($urandom_range(0, 99) < 3) begin
                op = rnd7();
                while (legal(op)) op = rnd7();
            end else begin
                case ($urandom_range(0, 3))
                    0: op = ADDI;
                    1: op = ADD;
                    2: op = BEQ;
                    default: op = JAL;
                endcase
            end
            do_instr(op, $urandom_range(0, 5), rndb(), cont, trapped);
            if (trapped) begin
                trap_cycles(3);
                do_reset();
                cont = 1'b0;
            end
        end

        run_pct = 100;
        if (!cont) go_idle_then_start();
        do_instr(7'b0000011, 0, 1'b0, cont, trapped);
        trap_cycles(1);
        @(negedge clk);
        check("illegal_trap_state", 32'(state_o), 32'd5);
        check("illegal_trap_flag", 32'(trap), 32'd1);
        trap_cycles(5);
        do_reset();

        // Reset lands in the middle of an add's EXEC cycle.
        step(1'b1, 1'b0, rnd7(), 1'b0, mk(3'd0));
        e = mk(3'd1); e.req = 1'b1; e.irw = 1'b1;
        step(1'b1, 1'b1, rnd7(), 1'b0, e);
        step(1'b1, 1'b0, ADD, 1'b0, mk(3'd2));
        step(1'b1, 1'b0, ADD, 1'b0, mk(3'd3));
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        g_rst  = 1'b0;
        arst_n = 1'b0;
        m_ret  = 32'd0;
        #1;
        check("midreset_state", 32'(state_o), 32'd0);
        check("midreset_reg_write", 32'(reg_write), 32'd0);
        check("midreset_pc_write", 32'(pc_write), 32'd0);
        check("midreset_retired", retired, 32'd0);
        step(1'b1, 1'b0, ADD, 1'b0, mk(3'd0));
        g_rst = 1'b1;
        step(1'b1, 1'b0, rnd7(), 1'b0, mk(3'd0));

        // Fetch timeout: 16 unacknowledged FETCH cycles, then a permanent trap.
        do_instr(ADDI, 0, 1'b0, cont, trapped);
        for (int k = 0; k < 16; k++) begin
            e = mk(3'd1); e.req = 1'b1;
            step(1'b1, 1'b0, rnd7(), rndb(), e);
        end
        trap_cycles(1);
        @(negedge clk);
        check("timeout_trap_state", 32'(state_o), 32'd5);
        check("timeout_retired", retired, 32'd1);
        trap_cycles(50);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
